adc_frame_capture: RTL



---
 rtl/adc_frame_capture.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_frame_capture.sv
// Registers raw ADC samples, optionally decimates, waits for a rising level crossing, then streams
// one frame into the FIFO write port: 2-cycle sample-to-write latency, a tick with almost_full aborts.
module adc_frame_capture #(
  parameter int c_ADC_WIDTH   = 8,
  parameter int c_FRAME_LEN   = 1024,
  parameter int c_CNT_WIDTH   = 11,
  parameter int c_DECIM_WIDTH = 8,
  parameter int c_TWOS_COMP   = 1
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic [c_ADC_WIDTH-1:0]   adc_data,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     trig_en,
  input  logic [c_ADC_WIDTH-1:0]   trig_level,
  input  logic [c_DECIM_WIDTH-1:0] decim,
  input  logic                     almost_full,
  output logic [c_ADC_WIDTH-1:0]   wr_data,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [c_CNT_WIDTH-1:0]   sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [c_CNT_WIDTH-1:0]   c_LAST    = c_CNT_WIDTH'(c_FRAME_LEN - 1);
  localparam logic [c_CNT_WIDTH-1:0]   c_CNT_ONE = {{(c_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [c_DECIM_WIDTH-1:0] c_DEC_ONE = {{(c_DECIM_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_q;
  logic [c_ADC_WIDTH-1:0]   adc_d1_q;
  logic [c_ADC_WIDTH-1:0]   adc_d2_q;
  logic [c_ADC_WIDTH-1:0]   wr_data_q;
  logic                     wr_en_q;
  logic                     busy_q;
  logic                     frame_done_q;
  logic                     overflow_q;
  logic [c_CNT_WIDTH-1:0]   sample_cnt_q;
  logic [c_DECIM_WIDTH-1:0] decim_cnt_q;
  logic [c_DECIM_WIDTH-1:0] decim_lat_q;

  logic [c_ADC_WIDTH-1:0]   conv;
  logic                     trig_hit;
  logic                     tick;
  logic                     last_wr;

  always_comb begin
    conv = adc_d1_q;
    if (c_TWOS_COMP != 0) begin
      conv[c_ADC_WIDTH-1] = ~adc_d1_q[c_ADC_WIDTH-1];
    end
  end

  assign trig_hit = (adc_d2_q < trig_level) && (adc_d1_q >= trig_level);
  assign tick     = (decim_cnt_q == '0);
  assign last_wr  = (sample_cnt_q == c_LAST);

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      adc_d1_q <= '0;
      adc_d2_q <= '0;
    end else begin
      adc_d1_q <= adc_data;
      adc_d2_q <= adc_d1_q;
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q      <= S_IDLE;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
      decim_cnt_q  <= '0;
      decim_lat_q  <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      // busy trails the state by one cycle so it still covers the final write
      busy_q       <= (state_q != S_IDLE);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            overflow_q   <= 1'b0;
            sample_cnt_q <= '0;
            state_q      <= S_ARMED;
          end
        end

        S_ARMED: begin
          sample_cnt_q <= '0;
          if (!trig_en || trig_hit) begin
            decim_cnt_q <= '0;
            decim_lat_q <= decim;
            state_q     <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          // the decimation ratio is only picked up when the count wraps
          if (decim_cnt_q == decim_lat_q) begin
            decim_cnt_q <= '0;
            decim_lat_q <= decim;
          end else begin
            decim_cnt_q <= decim_cnt_q + c_DEC_ONE;
          end

          if (tick) begin
            if (almost_full) begin
              overflow_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              wr_data_q    <= conv;
              wr_en_q      <= 1'b1;
              sample_cnt_q <= sample_cnt_q + c_CNT_ONE;
              if (last_wr) begin
                frame_done_q <= 1'b1;
                state_q      <= cont ? S_ARMED : S_IDLE;
              end
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign sample_cnt = sample_cnt_q;

endmodule
